// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and break hold-off
module uart_receiver #(
    parameter int clk_freq  = 100000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clk_freq / baud_rate;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_params
        $error("uart_receiver: clk_freq/baud_rate must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_error_q, frame_error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sync1_d       = rxd;
        rx_s_d        = sync1_q;
        cnt_d         = cnt_q + CNT_W'(1);
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                // Counter restarts every bit so each sample stays on a bit centre.
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int LAT      = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    uart_receiver #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
        .clk(clk), .reset(reset), .rxd(rxd),
        .data(data), .data_valid(data_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         e_cyc[$];
    int busy_from = 0, busy_to = -1, busy_drop = 0;

    always @(negedge clk) begin
        if (data_valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(data);
        end
        if (frame_error) e_cyc.push_back(cyc);
        if (data_valid || frame_error) begin
            n_cmp++;
            if (data_valid && frame_error) begin
                n_bad++;
                $display("FAIL both_pulses: valid and frame_error both 1 at cycle %0d, required exclusive", cyc);
            end
        end
        if (cyc >= busy_from && cyc <= busy_to && !busy) busy_drop++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic bit_drive(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int start);
        start = cyc + 1;
        bit_drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_drive(b[i], CPB);
        bit_drive(stop, CPB);
    endtask

    task automatic clear_events();
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
    endtask

    task automatic check_frame(input string name, input logic exp_v, input logic exp_e,
                               input logic [7:0] exp_d, input int start);
        check($sformatf("%s/valid_count", name), v_cyc.size(), {31'd0, exp_v});
        check($sformatf("%s/error_count", name), e_cyc.size(), {31'd0, exp_e});
        if (exp_v && v_cyc.size() > 0) begin
            check_range($sformatf("%s/latency", name), v_cyc[0] - start, LAT - 1, LAT + 1);
            check($sformatf("%s/valid_data", name), v_dat[0], exp_d);
        end
        if (exp_e && e_cyc.size() > 0)
            check_range($sformatf("%s/error_latency", name), e_cyc[0] - start, LAT - 1, LAT + 1);
        check($sformatf("%s/data_out", name), data, exp_d);
        clear_events();
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         hold;
        logic       exp_v;
        logic       exp_e;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int         start, start2, k;
        logic [7:0] model_last;
        logic [7:0] rb;
        logic       rs;

        tbl[0] = '{8'h32, 1'b1, 0,  1'b1, 1'b0, 8'h32};
        tbl[1] = '{8'h7E, 1'b0, 30, 1'b0, 1'b1, 8'h32};
        tbl[2] = '{8'hFF, 1'b1, 0,  1'b1, 1'b0, 8'hFF};
        tbl[3] = '{8'h00, 1'b1, 0,  1'b1, 1'b0, 8'h00};
        tbl[4] = '{8'h00, 1'b0, 5,  1'b0, 1'b1, 8'h00};
        tbl[5] = '{8'h80, 1'b1, 0,  1'b1, 1'b0, 8'h80};
        tbl[6] = '{8'h01, 1'b0, 0,  1'b0, 1'b1, 8'h80};

        repeat (3) @(posedge clk);
        #1;
        check("reset/data", data, 8'h00);
        check("reset/data_valid", data_valid, 1'b0);
        check("reset/frame_error", frame_error, 1'b0);
        check("reset/busy", busy, 1'b0);
        reset = 1'b0;
        bit_drive(1'b1, 5);

        for (int i = 0; i < 7; i++) begin
            busy_drop = 0;
            busy_from = cyc + 3;
            busy_to   = tbl[i].exp_e ? 32'h3fffffff : cyc + LAT;
            send_frame(tbl[i].b, tbl[i].stop, start);
            check_frame($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_d, start);
            if (tbl[i].exp_e) begin
                if (tbl[i].hold > 0) bit_drive(1'b0, tbl[i].hold);
                rxd = 1'b1;
                busy_to = cyc + 2;
                bit_drive(1'b1, 4);
                check($sformatf("tbl%0d/no_spurious", i), v_cyc.size() + e_cyc.size(), 0);
            end
            check($sformatf("tbl%0d/busy_held", i), busy_drop, 0);
            check($sformatf("tbl%0d/busy_end", i), busy, 1'b0);
            busy_to = -1;
            clear_events();
            bit_drive(1'b1, 3);
        end

        // Glitch shorter than half a bit must be rejected without a pulse.
        bit_drive(1'b0, 3);
        rxd = 1'b1;
        k = 0;
        while (busy && k < HALF + 3) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("glitch/busy_drop", busy, 1'b0);
        bit_drive(1'b1, 20);
        check("glitch/no_events", v_cyc.size() + e_cyc.size(), 0);
        send_frame(8'hC3, 1'b1, start);
        check_frame("after_glitch", 1'b1, 1'b0, 8'hC3, start);
        bit_drive(1'b1, 5);

        send_frame(8'hA5, 1'b1, start);
        send_frame(8'h5A, 1'b1, start2);
        check("b2b/valid_count", v_cyc.size(), 2);
        if (v_cyc.size() == 2) begin
            check("b2b/first_data", v_dat[0], 8'hA5);
            check("b2b/second_data", v_dat[1], 8'h5A);
            check("b2b/spacing", v_cyc[1] - v_cyc[0], 10 * CPB);
            check_range("b2b/latency", v_cyc[0] - start, LAT - 1, LAT + 1);
        end
        check("b2b/error_count", e_cyc.size(), 0);
        clear_events();
        bit_drive(1'b1, 5);

        // Reset during bit 4 abandons the frame silently.
        bit_drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_drive(rb_bit(8'h81, i), CPB);
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset/busy", busy, 1'b0);
        check("midreset/data", data, 8'h00);
        check("midreset/data_valid", data_valid, 1'b0);
        bit_drive(1'b1, 3 * CPB);
        check("midreset/no_events", v_cyc.size() + e_cyc.size(), 0);
        send_frame(8'h81, 1'b1, start);
        check_frame("after_reset", 1'b1, 1'b0, 8'h81, start);

        model_last = 8'h81;
        for (int n = 0; n < 40; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rb, rs, start);
            if (rs) model_last = rb;
            check_frame($sformatf("rand%0d", n), rs, !rs, model_last, start);
            if (!rs) begin
                k = $urandom_range(0, 20);
                if (k > 0) bit_drive(1'b0, k);
                bit_drive(1'b1, $urandom_range(2, 6));
                check($sformatf("rand%0d/break_quiet", n), v_cyc.size() + e_cyc.size(), 0);
            end else begin
                k = $urandom_range(0, 12);
                if (k > 0) bit_drive(1'b1, k);
            end
        end
        bit_drive(1'b1, 20);
        check("final/no_events", v_cyc.size() + e_cyc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic rb_bit(input logic [7:0] b, input int i);
        return b[i];
    endfunction

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive side, paired with our `transmitter` (8N1, LSB first, idle-high line).
- Synchronises the asynchronous `rxd` line into `clk` and validates the start bit at mid-bit.
- Samples 8 data bits and the stop bit at their centres, then presents the byte with a one-cycle valid strobe.
- Parameters match the transmitter, so the two blocks loop back directly (`txd` to `rxd`).

Parameters:
- `clk_freq`, 100000000, system clock frequency in Hz.
- `baud_rate`, 9600, line bit rate in bits/s.
- Derived, not overridable: `CLKS_PER_BIT = clk_freq/baud_rate` (integer division). `HALF_BIT = CLKS_PER_BIT/2`.
- Elaboration must fail if `CLKS_PER_BIT < 4`.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rxd`  input  1  asynchronous serial input; idle = 1.
- `data`  output  8  last correctly framed byte; holds until the next good frame.
- `data_valid`  output  1  one-cycle pulse: `data` has just been updated.
- `frame_error`  output  1  one-cycle pulse: stop bit sampled as 0.
- `busy`  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge):
  - `data`=8'h00, `data_valid`=0, `frame_error`=0, `busy`=0.
  - Synchroniser flops = 1; state = IDLE; bit counter = 0; baud counter = 0.
  - Reset mid-frame abandons the frame with no pulse. Reset has priority over every other event.
- Synchroniser: 2-flop chain on `rxd`. All FSM decisions use the second flop (`rx_s`), so there is 2 cycles of input latency.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. Cleared on every state change; counts up each cycle within a state.
- FSM states:
  - IDLE: `busy`=0. When `rx_s`==0, go to START.
  - START: when the baud counter reaches `HALF_BIT-1`, sample `rx_s`.
    - If 0: go to DATA with bit index 0.
    - If 1: glitch; return to IDLE with no pulse.
  - DATA: when the baud counter reaches `CLKS_PER_BIT-1`, shift `rx_s` into the shift register MSB-ward (LSB received first).
    - Increment the bit index.
    - After the 8th sample (index 7), go to STOP.
  - STOP: when the baud counter reaches `CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1: `data` <= shift register; `data_valid`=1 for exactly one cycle; go to IDLE.
    - If 0: `frame_error`=1 for one cycle; `data` unchanged; go to BREAK.
  - BREAK: `busy`=1. Stay until `rx_s`==1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Sample timing: each data and stop sample lands at bit centre.
- Latency (exact): `data_valid` rises `2 + HALF_BIT + 9*CLKS_PER_BIT` cycles after the first clock edge at which `rxd` is seen low. The bench tolerates ±1 cycle for synchroniser phase.
- Back-to-back frames:
  - The receiver returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is caught with no lost frame.
  - `data_valid` and `frame_error` are never both high.
- `data_valid` does not wait for a consumer handshake. A byte not read before the next good frame is overwritten.

Test Plan (`clk_freq`=1000000, `baud_rate`=100000, so `CLKS_PER_BIT`=10, `HALF_BIT`=5; 10-cycle bit periods driven by the bench):
- Single frame 8'h32 (start, bits 0,1,0,0,1,1,0,0, stop) -> `data`=8'h32.
  - `data_valid` high exactly one cycle, 97±1 cycles after the start edge.
  - `busy` high from start detect until the valid cycle; `frame_error` stays 0.
- Back-to-back 8'hA5 then 8'h5A, no idle gap -> two `data_valid` pulses, 100 cycles apart, with `data`=8'hA5 then 8'h5A.
- Glitch: `rxd` low for 3 cycles, then high -> no `data_valid` and no `frame_error`; `busy` drops within `HALF_BIT`+3 cycles; a following 8'hC3 frame is received correctly.
- Bad stop: frame 8'h7E with the stop bit driven 0, line held low 30 more cycles, then high -> one `frame_error` pulse.
  - `data` keeps its previous value (8'h32 from the earlier frame).
  - `busy` stays high until the line returns high; no spurious 8'h00.
- Reset mid-frame: assert `reset` for 1 cycle during bit 4 of a frame -> next cycle `busy`=0, `data`=8'h00, no pulse; a following 8'h81 frame is received correctly.
- Loopback: `transmitter` (same parameters) `txd` wired to `rxd`; send 8'h32 with a one-cycle `transmit` pulse -> `data`=8'h32 with one `data_valid` before the transmitter's `busy` falls, `frame_error`=0.
